// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32I main-control decode with valid/ready output register.
// Optional illegal-opcode flag and saturating counter when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_ctrl_stage #(
    parameter int WIDTH_RS  = 2,
    parameter int WIDTH_IMM = 3,
    parameter int WIDTH_ALU = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           op,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 reg_write,
    output logic                 alu_src,
    output logic                 mem_write,
    output logic                 branch,
    output logic                 jump,
    output logic                 jump_src,
    output logic [WIDTH_RS-1:0]  result_src,
    output logic [WIDTH_IMM-1:0] imm_src,
    output logic [WIDTH_ALU-1:0] alu_op,
    output logic                 illegal,
    output logic [CNT_W-1:0]     illegal_cnt
);
    // {reg_write, imm_src[2:0], alu_src, mem_write, result_src[1:0], branch, alu_op[2:0], jump, jump_src}
    logic [13:0] d, q;
    logic        accept, take;

    always_comb begin
        d = '0;
        case (op)
            7'b0110011: d = 14'b1_000_0_0_00_0_000_0_0;
            7'b0000011: d = 14'b1_001_1_0_01_0_001_0_0;
            7'b0010011: d = 14'b1_001_1_0_00_0_000_0_0;
            7'b0100011: d = 14'b0_011_1_1_00_0_010_0_0;
            7'b1100011: d = 14'b0_100_0_0_00_1_011_0_0;
            7'b0010111: d = 14'b1_010_1_0_00_0_100_0_0;
            7'b0110111: d = 14'b1_010_1_0_00_0_101_0_0;
            7'b1100111: d = 14'b1_001_0_0_10_0_110_1_1;
            7'b1101111: d = 14'b1_101_0_0_10_0_111_1_0;
            default:    d = '0;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = accept && !flush;

    // Draining with no new accept clears the bundle so an idle stage always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush || accept || out_ready) begin
            out_valid <= take;
            q         <= take ? d : '0;
        end
    end

    assign reg_write  = q[13];
    assign imm_src    = WIDTH_IMM'(q[12:10]);
    assign alu_src    = q[9];
    assign mem_write  = q[8];
    assign result_src = WIDTH_RS'(q[7:6]);
    assign branch     = q[5];
    assign alu_op     = WIDTH_ALU'(q[4:2]);
    assign jump       = q[1];
    assign jump_src   = q[0];

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Every recognised opcode decodes to a non-zero bundle, so zero marks an unknown opcode.
    logic             ill_q;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
            cnt   <= '0;
        end else begin
            if (flush || accept || out_ready)
                ill_q <= take && (d == '0);
            if (take && (d == '0) && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end
    assign illegal     = ill_q;
    assign illegal_cnt = cnt;
`else
    assign illegal     = 1'b0;
    assign illegal_cnt = '0;
`endif
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed self-checking bench for decode_ctrl_stage (CNT_W=2).
module tb_decode_ctrl_stage;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [6:0] op;
    logic       reg_write, alu_src, mem_write, branch, jump, jump_src, illegal;
    logic [1:0] result_src, illegal_cnt;
    logic [2:0] imm_src, alu_op;
    logic [13:0] bundle;
    int checks = 0, failures = 0;
    logic [6:0]  ops  [9];
    logic [13:0] exps [9];
    logic [1:0]  cnt_seq [5];

    decode_ctrl_stage #(.CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .reg_write(reg_write), .alu_src(alu_src), .mem_write(mem_write), .branch(branch),
        .jump(jump), .jump_src(jump_src), .result_src(result_src), .imm_src(imm_src),
        .alu_op(alu_op), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;
    assign bundle = {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump, jump_src};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ops  = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                 7'b0010111, 7'b0110111, 7'b1100111, 7'b1101111};
        exps = '{14'b1_000_0_0_00_0_000_0_0, 14'b1_001_1_0_01_0_001_0_0, 14'b1_001_1_0_00_0_000_0_0,
                 14'b0_011_1_1_00_0_010_0_0, 14'b0_100_0_0_00_1_011_0_0, 14'b1_010_1_0_00_0_100_0_0,
                 14'b1_010_1_0_00_0_101_0_0, 14'b1_001_0_0_10_0_110_1_1, 14'b1_101_0_0_10_0_111_1_0};
`ifdef DECODE_ILLEGAL_TRAP_EN
        cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        cnt_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; op = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_bundle", 32'(bundle), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_cnt", 32'(illegal_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        tick;
        // back-to-back stream of all nine opcodes
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            op = ops[i];
            tick;
            chk($sformatf("b2b_valid_%0d", i), 32'(out_valid), 1);
            chk($sformatf("b2b_bundle_%0d", i), 32'(bundle), 32'(exps[i]));
        end
        in_valid = 1'b0;
        tick;
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_bundle", 32'(bundle), 0);
        // stall: LUI held while R waits
        in_valid = 1'b1; op = ops[6]; out_ready = 1'b0;
        tick;
        op = ops[0];
        #1;
        chk("stall_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("stall_bundle_%0d", i), 32'(bundle), 32'(exps[6]));
            chk($sformatf("stall_alu_op_%0d", i), 32'(alu_op), 3'b101);
            chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(in_ready), 1);
        tick;
        chk("unstall_valid", 32'(out_valid), 1);
        chk("unstall_bundle", 32'(bundle), 32'(exps[0]));
        in_valid = 1'b0;
        tick;
        // flush while held, JAL incoming
        in_valid = 1'b1; op = ops[6]; out_ready = 1'b0;
        tick;
        op = ops[8]; flush = 1'b1;
        #1;
        chk("flush_in_ready_stalled", 32'(in_ready), 0);
        tick;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_bundle", 32'(bundle), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        // flush with in_ready=1: incoming illegal discarded and not counted
        op = 7'b1111111; out_ready = 1'b1;
        tick;
        chk("flush_ill_valid", 32'(out_valid), 0);
        chk("flush_ill_illegal", 32'(illegal), 0);
        chk("flush_ill_cnt", 32'(illegal_cnt), 0);
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("ill_valid_%0d", i), 32'(out_valid), 1);
            chk($sformatf("ill_bundle_%0d", i), 32'(bundle), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk($sformatf("ill_flag_%0d", i), 32'(illegal), 1);
`else
            chk($sformatf("ill_flag_%0d", i), 32'(illegal), 0);
`endif
            chk($sformatf("ill_cnt_%0d", i), 32'(illegal_cnt), 32'(cnt_seq[i]));
        end
        op = 7'b0000000;
        tick;
        chk("zero_op_valid", 32'(out_valid), 1);
        chk("zero_op_bundle", 32'(bundle), 0);
        chk("zero_op_cnt", 32'(illegal_cnt), 32'(cnt_seq[4]));
        // async reset mid-stall
        in_valid = 1'b0; out_ready = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_bundle", 32'(bundle), 0);
        chk("arst_illegal", 32'(illegal), 0);
        chk("arst_cnt", 32'(illegal_cnt), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1; in_valid = 1'b1; op = ops[7]; out_ready = 1'b1;
        tick;
        chk("resume_valid", 32'(out_valid), 1);
        chk("resume_bundle", 32'(bundle), 32'(exps[7]));
        in_valid = 1'b0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
